// File: rtl/seven_seg_pkg.sv
// Shared digit codes, segment glyphs and helpers for the 7-segment scan driver.
package seven_seg_pkg;

    localparam int unsigned CODE_W = 5;
    typedef logic [CODE_W-1:0] digit_code_t;

    // Codes 0..15 are hex digits; the two extra codes are display-only symbols.
    localparam digit_code_t CODE_OFF  = 5'd16;
    localparam digit_code_t CODE_DASH = 5'd17;

    // Segment patterns {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] GLYPH_0    = 7'b0000001;
    localparam logic [6:0] GLYPH_1    = 7'b1001111;
    localparam logic [6:0] GLYPH_2    = 7'b0010010;
    localparam logic [6:0] GLYPH_3    = 7'b0000110;
    localparam logic [6:0] GLYPH_4    = 7'b1001100;
    localparam logic [6:0] GLYPH_5    = 7'b0100100;
    localparam logic [6:0] GLYPH_6    = 7'b0100000;
    localparam logic [6:0] GLYPH_7    = 7'b0001111;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0000100;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b1100000;
    localparam logic [6:0] GLYPH_C    = 7'b0110001;
    localparam logic [6:0] GLYPH_D    = 7'b1000010;
    localparam logic [6:0] GLYPH_E    = 7'b0110000;
    localparam logic [6:0] GLYPH_F    = 7'b0111000;
    localparam logic [6:0] GLYPH_OFF  = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH = 7'b1111110;

    // Digit code to segment pattern; anything unrecognised is dark.
    function automatic logic [6:0] glyph(input digit_code_t code);
        logic [6:0] g;
        case (code)
            5'd0:      g = GLYPH_0;
            5'd1:      g = GLYPH_1;
            5'd2:      g = GLYPH_2;
            5'd3:      g = GLYPH_3;
            5'd4:      g = GLYPH_4;
            5'd5:      g = GLYPH_5;
            5'd6:      g = GLYPH_6;
            5'd7:      g = GLYPH_7;
            5'd8:      g = GLYPH_8;
            5'd9:      g = GLYPH_9;
            5'd10:     g = GLYPH_A;
            5'd11:     g = GLYPH_B;
            5'd12:     g = GLYPH_C;
            5'd13:     g = GLYPH_D;
            5'd14:     g = GLYPH_E;
            5'd15:     g = GLYPH_F;
            CODE_DASH: g = GLYPH_DASH;
            default:   g = GLYPH_OFF;
        endcase
        return g;
    endfunction

    // 10**n, used for the decimal overflow threshold.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: IDLE -> SHIFT (BIN_W cycles) -> COMMIT (done) -> IDLE.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam int unsigned SH_W  = BCD_W + BIN_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   adj;
    logic [SH_W-1:0]    shifted;

    // Add-3 correction on every BCD nibble that is 5 or more, then shift in the next binary bit.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_sh_q} << 1;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_sh_d = bin_sh_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_sh_d = bin;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d    = shifted[SH_W-1:BIN_W];
                bin_sh_d = shifted[BIN_W-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_COMMIT;
                    done_d  = 1'b1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bin_sh_q <= '0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_sh_q <= bin_sh_d;
            bcd_q    <= bcd_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with hex/decimal load, blanking and overflow dashes.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              ready,
    input  logic              hex_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NIB_W = 4 * DIGITS;
    localparam int unsigned BUF_W = CODE_W * DIGITS;
    localparam int unsigned PAD_W = (BIN_W > NIB_W) ? BIN_W : NIB_W;
    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              mode_hex_q, mode_hex_d;
    logic              blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic [BUF_W-1:0]  disp_q, disp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              tick_c;
    logic              accept_c;
    logic              conv_start_c;
    logic              conv_done;
    logic [NIB_W-1:0]  conv_bcd;
    logic [PAD_W-1:0]  hex_ext;
    digit_code_t       cur_code;

    // Turn a nibble vector into display codes, applying overflow dashes and leading-zero blanking.
    function automatic logic [BUF_W-1:0] make_codes(input logic [NIB_W-1:0] nib,
                                                    input logic             blank,
                                                    input logic             ovf);
        logic [BUF_W-1:0] codes;
        logic             lead;
        digit_code_t      code;
        codes = '0;
        lead  = blank;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            code = {1'b0, nib[4*k +: 4]};
            if (ovf) begin
                code = CODE_DASH;
            end else if (lead && (k != 0) && (nib[4*k +: 4] == 4'd0)) begin
                code = CODE_OFF;
            end else begin
                lead = 1'b0;
            end
            codes[CODE_W*k +: CODE_W] = code;
        end
        return codes;
    endfunction

    assign accept_c     = load && ready_q;
    assign conv_start_c = accept_c && !hex_mode;
    assign hex_ext      = PAD_W'(bin_in);

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_c),
        .bin   (bin_in),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Refresh divider and scan index; the index steps once per terminal count.
    always_comb begin
        tick_c = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
        idx_d  = idx_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Handshake, captured load options and the committed display buffer.
    always_comb begin
        ready_d    = ready_q;
        mode_hex_d = mode_hex_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        if (accept_c) begin
            ready_d    = 1'b0;
            mode_hex_d = hex_mode;
            blank_d    = blank_lz;
            ovf_d      = !hex_mode && (64'(bin_in) >= OVF_LIMIT);
            if (hex_mode) begin
                disp_d = make_codes(hex_ext[NIB_W-1:0], blank_lz, 1'b0);
            end
        end else if (!ready_q) begin
            if (mode_hex_q) begin
                ready_d = 1'b1;
            end else if (conv_done) begin
                ready_d = 1'b1;
                disp_d  = make_codes(conv_bcd, blank_q, ovf_q);
            end
        end
    end

    // Anode, segments and dp all derive from the same next index so they switch together.
    always_comb begin
        cur_code = disp_d[CODE_W*32'(idx_d) +: CODE_W];
        seg_d    = glyph(cur_code);
        dp_d     = ~dp_in[idx_d];
        an_d     = ~(DIGITS'(1) << idx_d);
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            idx_q      <= '0;
            ready_q    <= 1'b1;
            mode_hex_q <= 1'b0;
            blank_q    <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= {DIGITS{CODE_OFF}};
            seg_q      <= GLYPH_OFF;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            mode_hex_q <= mode_hex_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign ready = ready_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with DIGITS=4, BIN_W=14, REFRESH_DIV=4.
module tb_seven_seg_scan_driver;

    localparam logic [6:0] G0    = 7'b0000001;
    localparam logic [6:0] G1    = 7'b1001111;
    localparam logic [6:0] G2    = 7'b0010010;
    localparam logic [6:0] G3    = 7'b0000110;
    localparam logic [6:0] G4    = 7'b1001100;
    localparam logic [6:0] G5    = 7'b0100100;
    localparam logic [6:0] G9    = 7'b0000100;
    localparam logic [6:0] GA    = 7'b0001000;
    localparam logic [6:0] GB    = 7'b1100000;
    localparam logic [6:0] GE    = 7'b0110000;
    localparam logic [6:0] GF    = 7'b0111000;
    localparam logic [6:0] GOFF  = 7'b1111111;
    localparam logic [6:0] GDASH = 7'b1111110;

    typedef struct {
        logic [13:0] val;
        logic        hex;
        logic        blank;
        int          lat;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [13:0] bin_in;
    logic        load;
    logic        ready;
    logic        hex_mode;
    logic        blank_lz;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks;
    int failures;

    seven_seg_scan_driver #(
        .DIGITS      (4),
        .BIN_W       (14),
        .REFRESH_DIV (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .load     (load),
        .ready    (ready),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sample at negedges for 20 cycles, recording the pattern seen under each anode.
    task automatic capture(output logic [27:0] segs, output logic [3:0] seen);
        logic [3:0] sel;
        segs = '0;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 4; k++) begin
                sel = ~(4'b0001 << k);
                if (an === sel) begin
                    segs[7*k +: 7] = seg;
                    seen[k]        = 1'b1;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_display(input string name, input logic [27:0] exp);
        logic [27:0] got;
        logic [3:0]  seen;
        capture(got, seen);
        chk({name, "_seen"}, 32'(seen), 32'hF);
        chk({name, "_segs"}, 32'(got), 32'(exp));
    endtask

    // Called just after a negedge: load one vector, measure ready-low time, then check the display.
    task automatic apply_vec(input vec_t v, input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rdy_pre"}, 32'(ready), 32'd1);
        bin_in   = v.val;
        hex_mode = v.hex;
        blank_lz = v.blank;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (ready === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_lat"}, 32'(n), 32'(v.lat));
        check_display(name, v.segs);
    endtask

    initial begin
        vec_t        tbl [12];
        logic [3:0]  seq [5];
        logic [27:0] exp1234;
        logic [3:0]  prev;
        logic        found;
        int          n;
        int          bad_seg;
        int          bad_dp;

        checks   = 0;
        failures = 0;

        tbl[0]  = '{val: 14'd255,    hex: 1'b0, blank: 1'b1, lat: 15, segs: {GOFF, G2, G5, G5}};
        tbl[1]  = '{val: 14'd0,      hex: 1'b0, blank: 1'b1, lat: 15, segs: {GOFF, GOFF, GOFF, G0}};
        tbl[2]  = '{val: 14'd10000,  hex: 1'b0, blank: 1'b0, lat: 15, segs: {GDASH, GDASH, GDASH, GDASH}};
        tbl[3]  = '{val: 14'd10000,  hex: 1'b0, blank: 1'b1, lat: 15, segs: {GDASH, GDASH, GDASH, GDASH}};
        tbl[4]  = '{val: 14'h2BEF,   hex: 1'b1, blank: 1'b0, lat: 1,  segs: {G2, GB, GE, GF}};
        tbl[5]  = '{val: 14'd1234,   hex: 1'b0, blank: 1'b0, lat: 15, segs: {G1, G2, G3, G4}};
        tbl[6]  = '{val: 14'd255,    hex: 1'b0, blank: 1'b0, lat: 15, segs: {G0, G2, G5, G5}};
        tbl[7]  = '{val: 14'h000A,   hex: 1'b1, blank: 1'b1, lat: 1,  segs: {GOFF, GOFF, GOFF, GA}};
        tbl[8]  = '{val: 14'd9999,   hex: 1'b0, blank: 1'b1, lat: 15, segs: {G9, G9, G9, G9}};
        tbl[9]  = '{val: 14'h3FFF,   hex: 1'b1, blank: 1'b0, lat: 1,  segs: {G3, GF, GF, GF}};
        tbl[10] = '{val: 14'd0,      hex: 1'b0, blank: 1'b0, lat: 15, segs: {G0, G0, G0, G0}};
        tbl[11] = '{val: 14'd100,    hex: 1'b0, blank: 1'b1, lat: 15, segs: {GOFF, G1, G0, G0}};

        seq     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp1234 = {G1, G2, G3, G4};

        rst_n    = 1'b0;
        bin_in   = '0;
        load     = 1'b0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        dp_in    = 4'b0000;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        check_display("rst_buf", {GOFF, GOFF, GOFF, GOFF});

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Scan order, slot length, anode/segment alignment and dp routing.
        dp_in = 4'b0100;
        apply_vec(tbl[5], "scan_load");
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
            prev = an;
        end
        chk("scan_sync", 32'(found), 32'd1);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("scan_an%0d", s), 32'(an), 32'(seq[s]));
            if (s < 4) begin
                n       = 0;
                bad_seg = 0;
                bad_dp  = 0;
                while (an === seq[s] && n < 10) begin
                    if (seg !== exp1234[7*s +: 7]) bad_seg++;
                    if (dp !== ((s == 2) ? 1'b0 : 1'b1)) bad_dp++;
                    n++;
                    @(negedge clk);
                end
                chk($sformatf("scan_len%0d", s), 32'(n), 32'd4);
                chk($sformatf("scan_seg%0d", s), 32'(bad_seg), 32'd0);
                chk($sformatf("scan_dp%0d", s), 32'(bad_dp), 32'd0);
            end
        end

        // Asynchronous reset mid-scan.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'd1);
        chk("arst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dp_in = 4'b0000;
        check_display("arst_buf", {GOFF, GOFF, GOFF, GOFF});

        // Load while busy is dropped; the original conversion completes untouched.
        bin_in   = 14'd1234;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_at_pulse", 32'(ready), 32'd0);
        bin_in = 14'd9999;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (ready === 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("ignored_lat", 32'(n), 32'd10);
        check_display("ignored", exp1234);

        // Reset during a conversion aborts it and clears the buffer.
        bin_in = 14'd1234;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_an", 32'(an), 32'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready_rel", 32'(ready), 32'd1);
        check_display("abort_buf", {GOFF, GOFF, GOFF, GOFF});

        // Normal operation resumes after the abort.
        apply_vec(tbl[0], "resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
